// File: rtl/game_index_allocator_if.sv
// Bundles the request/result and release signals of the game slot allocator.
//   clear          : synchronous free-all / abort
//   req, start     : allocation request and circular scan start slot
//   release_en     : free slot release_index this cycle ("release" is a
//   release_index    reserved word, hence the _en suffix)
//   busy, done     : scanning flag and one-cycle end-of-attempt pulse
//   valid, index   : result of the last attempt, held until the next done
//   free_count     : registered number of free slots
//   state_dbg      : FSM state, exposed for checkers
// Handshake: req is sampled only when the allocator is idle (busy=0, done=0);
// the attempt completes with exactly one done pulse, after which valid/index
// describe it. Requests while busy or during done are dropped, not queued.
interface game_index_allocator_if #(
  parameter int N     = 128,
  parameter int LANES = 8
);
  localparam int IW = $clog2(N);

  logic          clear;
  logic          req;
  logic [IW-1:0] start;
  logic          release_en;
  logic [IW-1:0] release_index;
  logic          busy;
  logic          done;
  logic          valid;
  logic [IW-1:0] index;
  logic [IW:0]   free_count;
  logic [1:0]    state_dbg;

  modport master (
    output clear, req, start, release_en, release_index,
    input  busy, done, valid, index, free_count, state_dbg
  );

  modport slave (
    input  clear, req, start, release_en, release_index,
    output busy, done, valid, index, free_count, state_dbg
  );
endinterface

// File: rtl/game_index_allocator.sv
// Game slot allocator. Keeps one occupancy bit per slot and, on request,
// scans LANES slots per cycle in circular order from a caller-supplied start
// slot, granting the first free one. A full circle with no free slot ends the
// attempt with valid=0.
//   clock, reset_n : clock, asynchronous active-low reset
//   bus (slave)    : request/result/release bundle, see game_index_allocator_if
// N must be a multiple of LANES; LANES must be a power of two, <= N.
module game_index_allocator #(
  parameter int N     = 128,
  parameter int LANES = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  game_index_allocator_if.slave bus
);
  localparam int          IW      = $clog2(N);
  localparam logic [IW:0] N_V     = (IW+1)'(N);
  localparam logic [IW:0] LANES_V = (IW+1)'(LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [N-1:0]  used;
  logic [IW-1:0] ptr;
  logic [IW:0]   scanned;
  logic          validQ;
  logic [IW-1:0] indexQ;
  logic [IW:0]   freeCount;

  // (base + offs) mod N; base < N and offs <= N, so one subtraction suffices.
  function automatic logic [IW-1:0] wrapAdd(input logic [IW-1:0] base,
                                            input logic [IW:0]   offs);
    logic [IW+1:0] sum;
    sum = {2'b00, base} + {1'b0, offs};
    if (sum >= {1'b0, N_V}) sum = sum - {1'b0, N_V};
    return sum[IW-1:0];
  endfunction

  // Window search over registered used bits. Walking lanes from the top down
  // leaves the lowest free offset from ptr as the winner.
  logic          hit;
  logic [IW-1:0] hitSlot;
  logic [IW-1:0] laneSlot;

  always_comb begin
    hit      = 1'b0;
    hitSlot  = '0;
    laneSlot = '0;
    for (int j = LANES - 1; j >= 0; j--) begin
      laneSlot = wrapAdd(ptr, (IW+1)'(j));
      if (!used[laneSlot]) begin
        hit     = 1'b1;
        hitSlot = laneSlot;
      end
    end
  end

  logic          relInRange;
  logic          relEffective;
  logic          allocate;
  logic          lastWindow;
  logic [IW-1:0] startEff;

  always_comb begin
    relInRange   = {1'b0, bus.release_index} < N_V;
    // Releasing a slot that is already free must not bump the count.
    relEffective = bus.release_en && relInRange && used[bus.release_index];
    allocate     = (state == SCAN) && hit;
    lastWindow   = (scanned + LANES_V) == N_V;
    startEff     = ({1'b0, bus.start} < N_V) ? bus.start : '0;
  end

  // FSM next state; clear overrides everything and returns to IDLE silently.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.req) stateNext = SCAN;
      SCAN:    if (hit || lastWindow) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (bus.clear) stateNext = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      used      <= '0;
      ptr       <= '0;
      scanned   <= '0;
      validQ    <= 1'b0;
      indexQ    <= '0;
      freeCount <= N_V;
    end else if (bus.clear) begin
      // Result registers deliberately keep the last completed attempt.
      used      <= '0;
      freeCount <= N_V;
    end else begin
      if (state == IDLE && bus.req) begin
        ptr     <= startEff;
        scanned <= '0;
      end

      if (state == SCAN) begin
        if (hit) begin
          indexQ <= hitSlot;
          validQ <= 1'b1;
        end else begin
          ptr     <= wrapAdd(ptr, LANES_V);
          scanned <= scanned + LANES_V;
          if (lastWindow) begin
            validQ <= 1'b0;
            indexQ <= '0;
          end
        end
      end

      // A releasable slot is occupied and the granted slot is free, so the
      // two writes never target the same bit.
      if (relEffective) used[bus.release_index] <= 1'b0;
      if (allocate)     used[hitSlot]           <= 1'b1;

      case ({relEffective, allocate})
        2'b10:   freeCount <= freeCount + 1'b1;
        2'b01:   freeCount <= freeCount - 1'b1;
        default: freeCount <= freeCount;
      endcase
    end
  end

  assign bus.busy       = (state == SCAN);
  assign bus.done       = (state == DONE);
  assign bus.valid      = validQ;
  assign bus.index      = indexQ;
  assign bus.free_count = freeCount;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_game_index_allocator.sv
// Bench for game_index_allocator (N=128, LANES=8). Inputs change and outputs
// are sampled on the falling clock edge. The reference keeps a plain array of
// occupied slots and finds the grant by walking slots circularly from start.
module tb_game_index_allocator;
  localparam int N       = 128;
  localparam int LANES   = 8;
  localparam int IW      = $clog2(N);
  localparam int WINDOWS = N / LANES;

  logic clock;
  logic reset_n;

  game_index_allocator_if #(.N(N), .LANES(LANES)) bus ();

  game_index_allocator #(.N(N), .LANES(LANES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int            nCompared   = 0;
  int            nMismatched = 0;
  bit            modelUsed[N];
  logic          lastValid;
  logic [IW-1:0] lastIndex;
  logic [IW-1:0] exp_q[$];

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_free();
    int c;
    c = 0;
    foreach (modelUsed[i]) if (!modelUsed[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    foreach (modelUsed[i]) modelUsed[i] = 1'b0;
  endtask

  // One allocation attempt. Optionally releases slot rel on scan edge relEdge
  // (edges counted after the request edge); holdReq keeps req high throughout.
  // Called and returns just after a falling edge.
  task automatic do_alloc(input int s, input bit holdReq, input int rel, input int relEdge);
    int sEff, expWin, expIdx, cycles, freeAfter, slot;
    bit expValid, relEff, occ;
    bit post[N];

    sEff   = (s >= N) ? 0 : s;
    relEff = (rel >= 0) && modelUsed[rel];
    post   = modelUsed;
    if (relEff) post[rel] = 1'b0;
    expValid = 1'b0;
    expIdx   = 0;
    expWin   = WINDOWS;
    // A release on edge r is first seen by the window examined on edge r+1.
    for (int k = 0; k < N; k++) begin
      slot = (sEff + k) % N;
      occ  = (rel >= 0 && k >= relEdge * LANES) ? post[slot] : modelUsed[slot];
      if (!occ) begin
        expValid = 1'b1;
        expIdx   = slot;
        expWin   = k / LANES + 1;
        break;
      end
    end
    freeAfter = model_free() + (relEff ? 1 : 0) - (expValid ? 1 : 0);
    exp_q.push_back(IW'(expIdx));

    bus.req   = 1'b1;
    bus.start = IW'(s);
    @(negedge clock);
    if (!holdReq) bus.req = 1'b0;
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < WINDOWS + 2) begin
      chk("busy_scan", bus.busy, 1);
      bus.release_en    = (rel >= 0) && (cycles == relEdge - 1);
      bus.release_index = IW'((rel < 0) ? 0 : rel);
      @(negedge clock);
      cycles++;
    end
    bus.release_en = 1'b0;
    bus.req        = 1'b0;
    chk("done_latency", cycles, expWin);
    chk("valid", bus.valid, expValid);
    chk("index", bus.index, exp_q.pop_front());
    chk("free_count_alloc", bus.free_count, freeAfter);

    modelUsed = post;
    if (expValid) modelUsed[expIdx] = 1'b1;
    lastValid = expValid;
    lastIndex = IW'(expIdx);

    @(negedge clock);
    chk("done_one_cycle", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
    if (holdReq) begin
      @(negedge clock);
      chk("req_not_queued", bus.busy, 0);
    end
  endtask

  task automatic do_release(input int idx);
    bus.release_en    = 1'b1;
    bus.release_index = IW'(idx);
    if (idx < N && modelUsed[idx]) modelUsed[idx] = 1'b0;
    @(negedge clock);
    bus.release_en = 1'b0;
    chk("free_count_release", bus.free_count, model_free());
  endtask

  initial begin
    bit sawDone;

    reset_n           = 1'b0;
    bus.clear         = 1'b0;
    bus.req           = 1'b0;
    bus.start         = '0;
    bus.release_en    = 1'b0;
    bus.release_index = '0;
    model_reset();
    lastValid = 1'b0;
    lastIndex = '0;

    repeat (3) @(negedge clock);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_valid", bus.valid, 0);
    chk("reset_index", bus.index, 0);
    chk("reset_free_count", bus.free_count, N);

    // First request rides the first rising edge after reset release.
    reset_n = 1'b1;
    do_alloc(50, 1'b0, -1, 0);

    // Random traffic
    repeat (20) do_alloc($urandom_range(0, N - 1), 1'b0, -1, 0);
    repeat (10) do_release($urandom_range(0, N - 1));
    repeat (10) do_alloc($urandom_range(0, N - 1), 1'b0, $urandom_range(0, N - 1), 1);

    // Fill the whole array
    while (model_free() > 0) do_alloc($urandom_range(0, N - 1), 1'b0, -1, 0);

    do_release(60);
    do_alloc(50, 1'b0, -1, 0);
    // Full array: complete circle, req held high the whole time
    do_alloc(5, 1'b1, -1, 0);
    // Only slot 3 free, scan wraps past the top
    do_release(3);
    do_alloc(120, 1'b0, -1, 0);
    // Slot 9 freed on the same edge its window is examined
    do_alloc(0, 1'b0, 9, 2);
    do_alloc(0, 1'b0, -1, 0);

    // clear in the middle of a full-array scan
    bus.req   = 1'b1;
    bus.start = IW'(5);
    @(negedge clock);
    bus.req = 1'b0;
    @(negedge clock);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    model_reset();
    chk("clear_busy", bus.busy, 0);
    chk("clear_done", bus.done, 0);
    chk("clear_free_count", bus.free_count, N);
    chk("clear_valid_kept", bus.valid, lastValid);
    chk("clear_index_kept", bus.index, lastIndex);
    sawDone = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (bus.done === 1'b1) sawDone = 1'b1;
    end
    chk("clear_no_done", sawDone, 0);
    do_alloc(0, 1'b0, -1, 0);

    // Allocation and release on the same edge; then a no-op release
    do_alloc(0, 1'b0, 0, 1);
    do_release(5);
    do_release(5);

    // Mixed random traffic
    repeat (15) begin
      if ($urandom_range(0, 2) == 0) do_release($urandom_range(0, N - 1));
      else do_alloc($urandom_range(0, N - 1), 1'b0,
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1, 1);
    end

    // Reset asserted while scanning
    bus.req   = 1'b1;
    bus.start = IW'($urandom_range(0, N - 1));
    @(negedge clock);
    bus.req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_valid", bus.valid, 0);
    chk("rst_mid_index", bus.index, 0);
    chk("rst_mid_free_count", bus.free_count, N);
    model_reset();
    lastValid = 1'b0;
    lastIndex = '0;
    @(negedge clock);
    chk("rst_hold_done", bus.done, 0);
    reset_n = 1'b1;
    do_alloc(77, 1'b0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
